ps2_cmd_scheduler: RTL
======================

// Module: ps2_cmd_scheduler
// PURPOSE
//  Sits between PS2_Controller (received_data/received_data_en) and the Tetris game FSM.
//  Parses make, break and extended (E0) scancode sequences and tracks which game keys are held.
//  Generates game commands with delayed auto-repeat (DAS) and queues them in a small FIFO.
//  Commands leave through a valid/ready handshake.
// PARAMETERS
//  DAS_DELAY   12_500_000  cycles from key press to first repeat (250 ms @ 50 MHz)
//  DAS_PERIOD  2_500_000   cycles between later repeats (50 ms)
//  CNT_W       24          repeat-timer width; must hold DAS_DELAY
//  FIFO_DEPTH  4           command FIFO entries (power of 2)
// PORTS
//  CLOCK_50        in   1  system clock
//  reset           in   1  synchronous, active-high reset
//  ps2_byte        in   8  scancode byte from PS2_Controller
//  ps2_byte_valid  in   1  one-cycle strobe, ps2_byte valid
//  cmd_ready       in   1  game FSM accepts cmd_code this cycle
//  cmd_valid       out  1  cmd_code holds a queued command
//  cmd_code        out  8  65 = left, 68 = right, 83 = soft drop, 32 = rotate
//  keys_held       out  4  {rotate, down, right, left}, 1 = held
//  overflow        out  1  sticky: a command was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (sync, active-high):
//   - parser state = IDLE
//   - FIFO empty; cmd_valid = 0, cmd_code = 0
//   - keys_held = 0, overflow = 0
//   - repeat key = none, repeat timer = 0
//  Key map:
//   - left:   1C (A), E0 6B
//   - right:  23 (D), E0 74
//   - down:   1B (S), E0 72
//   - rotate: 29 (space), E0 75
//  Parser FSM (advances only when ps2_byte_valid = 1):
//   - IDLE: E0 -> EXT; F0 -> BRK; mapped code -> make event, stay IDLE; other -> IDLE
//   - EXT:  F0 -> EXT_BRK; mapped E0 code -> make event, then IDLE; other -> IDLE
//   - BRK:  mapped code -> break event, then IDLE; F0 -> stay BRK; other -> IDLE
//   - EXT_BRK: mapped E0 code -> break event, then IDLE; other -> IDLE
//  Make event:
//   - Key already held (keyboard typematic repeat): ignored, no command.
//   - Otherwise: set keys_held bit and enqueue the key's command.
//   - Left, right and down also become the repeat key; timer loads DAS_DELAY.
//     A newer press replaces any older repeat key.
//   - Rotate never repeats and does not change the repeat key.
//  Break event:
//   - Clears the keys_held bit.
//   - If the key is the repeat key: repeat key = none, timer stops.
//   - No fallback to other keys that are still held.
//  Repeat timer:
//   - Decrements once per cycle while a repeat key exists.
//   - At 0: request a repeat command and reload DAS_PERIOD.
//   - Result: first repeat DAS_DELAY cycles after the make cycle, then one every DAS_PERIOD.
//  Enqueue arbitration:
//   - Make-event command has priority over a repeat request in the same cycle.
//   - The losing repeat request is held pending; it enqueues next cycle and the timer does not reload until then.
//  FIFO:
//   - Push is accepted if not full, or if a pop (cmd_valid & cmd_ready) occurs in the same cycle.
//   - Otherwise the command is dropped and overflow = 1 until reset.
//   - cmd_code/cmd_valid are driven from the head entry; cmd_code is stable while cmd_valid = 1 and cmd_ready = 0.
//   - Latency: strobe at cycle N into an empty FIFO -> cmd_valid = 1 at N+1.
//   - Push and pop on the same cycle leave the count unchanged; pointers wrap modulo FIFO_DEPTH.
//  Reset asserted mid-sequence (for example after E0 F0): parser, FIFO and timer all clear; the next byte is parsed from IDLE.
// TESTING  (DAS_DELAY = 20, DAS_PERIOD = 5, FIFO_DEPTH = 4)
//  - Byte 1C, cmd_ready = 1 -> cmd 65 at N+1; cmds 65 at N+20, N+25, N+30; bytes F0 1C -> repeats stop, keys_held = 0.
//  - Bytes 1C 1C 1C (typematic), then F0 1C -> exactly one cmd 65 before any DAS repeat; keys_held[0] falls after the break.
//  - Bytes E0 75, then E0 F0 75 -> single cmd 32, never repeats; keys_held[3] is 1 until the break completes.
//  - Hold A, press 23 -> cmd 68, repeats switch to 68; release D while A is held -> no further repeats.
//  - cmd_ready = 0, 5 distinct presses -> 4 queued in order, overflow = 1; drain -> order 65, 68, 83, 32.
//  - Bytes E0 F0, reset for 1 cycle, then 1C -> cmd 65 is queued, no break is applied, overflow = 0.
//  - Repeat timer expiring on the same cycle as a make strobe -> make cmd first, repeat cmd next cycle.

Source files
------------

// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler: PS/2 scancode parser with held-key tracking, DAS auto-repeat and a command FIFO.
module ps2_cmd_scheduler #(
  parameter int DAS_DELAY  = 12_500_000,
  parameter int DAS_PERIOD = 2_500_000,
  parameter int CNT_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [3:0] keys_held,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t st_q, st_d;
  logic n_hit, e_hit, hit, ext, make_ev, brk_ev, make_new, rep_req, push, pop, push_ok;
  logic [1:0] n_idx, e_idx, ev_idx;
  logic [7:0] push_code;
  logic [3:0] keys_q;
  logic rep_act_q, ovf_q;
  logic [1:0] rep_key_q;
  logic [CNT_W-1:0] tmr_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [7:0] code_of(input logic [1:0] k);
    return k == 2'd0 ? 8'd65 : k == 2'd1 ? 8'd68 : k == 2'd2 ? 8'd83 : 8'd32;
  endfunction
  assign n_hit = ps2_byte inside {8'h1C, 8'h23, 8'h1B, 8'h29};
  assign e_hit = ps2_byte inside {8'h6B, 8'h74, 8'h72, 8'h75};
  assign n_idx = ps2_byte == 8'h23 ? 2'd1 : ps2_byte == 8'h1B ? 2'd2 : ps2_byte == 8'h29 ? 2'd3 : 2'd0;
  assign e_idx = ps2_byte == 8'h74 ? 2'd1 : ps2_byte == 8'h72 ? 2'd2 : ps2_byte == 8'h75 ? 2'd3 : 2'd0;
  assign ext = st_q == EXT || st_q == EXT_BRK;
  assign hit = ext ? e_hit : n_hit;
  assign ev_idx = ext ? e_idx : n_idx;
  assign make_ev = ps2_byte_valid && hit && (st_q == IDLE || st_q == EXT);
  assign brk_ev = ps2_byte_valid && hit && (st_q == BRK || st_q == EXT_BRK);
  assign make_new = make_ev && !keys_q[ev_idx];
  always_comb begin
    st_d = !ps2_byte_valid ? st_q :
           st_q == IDLE ? (ps2_byte == 8'hE0 ? EXT : ps2_byte == 8'hF0 ? BRK : IDLE) :
           st_q == EXT  ? (ps2_byte == 8'hF0 ? EXT_BRK : IDLE) :
           st_q == BRK  ? (ps2_byte == 8'hF0 ? BRK : IDLE) : IDLE;
  end
  // Timer is loaded one short so the first repeat lands DAS_DELAY cycles after the make strobe.
  assign rep_req = rep_act_q && tmr_q == CNT_W'(1);
  assign push = make_new || rep_req;
  assign push_code = make_new ? code_of(ev_idx) : code_of(rep_key_q);
  assign cmd_valid = cnt_q != '0;
  assign pop = cmd_valid && cmd_ready;
  assign push_ok = cnt_q != CW'(FIFO_DEPTH) || pop;
  assign cmd_code = cmd_valid ? mem_q[rd_q] : 8'd0;
  assign keys_held = keys_q;
  assign overflow = ovf_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st_q <= IDLE;
      keys_q <= '0;
      rep_act_q <= 1'b0;
      rep_key_q <= 2'd0;
      tmr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
    end else begin
      st_q <= st_d;
      if (make_new) keys_q[ev_idx] <= 1'b1;
      else if (brk_ev) keys_q[ev_idx] <= 1'b0;
      // A repeat that loses to a make command keeps the timer parked at 1 and fires next cycle.
      if (make_new && ev_idx != 2'd3) begin
        rep_act_q <= 1'b1;
        rep_key_q <= ev_idx;
        tmr_q <= CNT_W'(DAS_DELAY - 1);
      end else if (brk_ev && rep_act_q && ev_idx == rep_key_q) begin
        rep_act_q <= 1'b0;
        tmr_q <= '0;
      end else if (rep_act_q && !(rep_req && make_new)) begin
        tmr_q <= rep_req ? CNT_W'(DAS_PERIOD) : tmr_q - CNT_W'(1);
      end
      if (push && push_ok) begin
        mem_q[wr_q] <= push_code;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push && push_ok) - CW'(pop);
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end
endmodule
